// File: rtl/bp_me_pkg.sv
// Shared ME-side types. The arbiter statistics record is only used when
// BP_ME_MEM_ARBITER_STATS_EN is defined.
package bp_me_pkg;

  typedef struct packed {
    logic [31:0] stall;
    logic [31:0] grant;
  } bp_me_mem_arb_stats_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/ready on the write side and valid/yumi on the read side.
// ready_o depends only on occupancy, so a pop never frees a slot for a same-cycle push.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p = 4,
  localparam int unsigned ptr_width_lp = $clog2(els_p),
  localparam int unsigned count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [width_p-1:0]        data_i,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      yumi_i,
  output logic [count_width_lp-1:0] count_o
);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic [count_width_lp-1:0] count;
  logic push, pop;

  assign ready_o = (count != count_width_lp'(els_p));
  assign v_o     = (count != '0);
  assign data_o  = mem[rd_ptr];
  assign count_o = count;
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // els_p is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + count_width_lp'(push) - count_width_lp'(pop);
    end
  end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// Round-robin arbiter sharing one in-order bp_mem port between num_req_p requesters.
// Define BP_ME_MEM_ARBITER_STATS_EN to add per-requester grant/stall counters on stats_o.
module bp_me_mem_arbiter #(
  parameter int unsigned num_req_p = 2,
  parameter int unsigned msg_width_p = 512,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned out_width_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_ready_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_yumi_i,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
`ifdef BP_ME_MEM_ARBITER_STATS_EN
  output logic [num_req_p*64-1:0]          stats_o,
`endif
  output logic [out_width_lp-1:0]          outstanding_o
);

  typedef logic [lg_num_req_lp-1:0] id_t;

  id_t rr_ptr, grant, head;
  logic any_v, fifo_ready, fifo_v, push, pop, resp_routed;

  // Rotate-priority encoder: first valid requester at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    grant = '0;
    any_v = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!any_v && mem_cmd_v_i[idx]) begin
        grant = id_t'(idx);
        any_v = 1'b1;
      end
    end
  end

  assign mem_cmd_o   = mem_cmd_i[grant*msg_width_p +: msg_width_p];
  assign mem_cmd_v_o = reset_n_i & any_v & fifo_ready;
  assign push        = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    mem_cmd_ready_o        = '0;
    mem_cmd_ready_o[grant] = reset_n_i & mem_cmd_ready_i & fifo_ready;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant == id_t'(num_req_p - 1)) ? '0 : grant + 1'b1;
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p (lg_num_req_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (push),
    .ready_o   (fifo_ready),
    .data_i    (grant),
    .v_o       (fifo_v),
    .data_o    (head),
    .yumi_i    (pop),
    .count_o   (outstanding_o)
  );

  // A response with no tag outstanding is never routed.
  assign resp_routed     = reset_n_i & mem_resp_v_i & fifo_v;
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = mem_resp_yumi_i[head] & resp_routed;
  assign pop             = mem_resp_yumi_o;

  always_comb begin
    mem_resp_v_o       = '0;
    mem_resp_v_o[head] = resp_routed;
  end

  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(mem_resp_v_i && !fifo_v))
    else $warning("bp_me_mem_arbiter: memory response with no tag outstanding");

  a_stray_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (mem_resp_yumi_i & ~mem_resp_v_o) == '0)
    else $error("bp_me_mem_arbiter: yumi on a requester without a routed response");

  a_count_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (32'(outstanding_o) <= max_outstanding_p) && !(pop && outstanding_o == '0))
    else $error("bp_me_mem_arbiter: outstanding count out of range");

`ifdef BP_ME_MEM_ARBITER_STATS_EN
  import bp_me_pkg::*;

  bp_me_mem_arb_stats_s [num_req_p-1:0] stats;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stats <= '0;
    end else begin
      for (int unsigned r = 0; r < num_req_p; r++) begin
        if (mem_cmd_v_i[r] && mem_cmd_ready_o[r] && stats[r].grant != '1) begin
          stats[r].grant <= stats[r].grant + 1'b1;
        end
        if (mem_cmd_v_i[r] && !mem_cmd_ready_o[r] && stats[r].stall != '1) begin
          stats[r].stall <= stats[r].stall + 1'b1;
        end
      end
    end
  end

  assign stats_o = stats;

  final begin
    for (int unsigned r = 0; r < num_req_p; r++) begin
      $display("bp_me_mem_arbiter: req %0d grants=%0d stalls=%0d", r, stats[r].grant,
               stats[r].stall);
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Directed bench for bp_me_mem_arbiter: vector table, hand sequences and an in-order memory model.
// Covers the stats port when BP_ME_MEM_ARBITER_STATS_EN is defined.
module tb_bp_me_mem_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] cmd_in;
  logic [N-1:0]   cmd_v;
  logic [N-1:0]   cmd_rdy;
  logic [W-1:0]   resp_out;
  logic [N-1:0]   resp_v;
  logic [N-1:0]   yumi_in;
  logic [W-1:0]   mcmd;
  logic           mcmd_v;
  logic           mcmd_rdy;
  logic [W-1:0]   mresp;
  logic           mresp_v;
  logic           myumi;
  logic [2:0]     outstanding;
`ifdef BP_ME_MEM_ARBITER_STATS_EN
  logic [N*64-1:0] stats;
`endif

  int total = 0;
  int bad = 0;
  int glog[$];

  always #5 clk = ~clk;

  bp_me_mem_arbiter #(
    .num_req_p         (N),
    .msg_width_p       (W),
    .max_outstanding_p (D)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .mem_cmd_i       (cmd_in),
    .mem_cmd_v_i     (cmd_v),
    .mem_cmd_ready_o (cmd_rdy),
    .mem_resp_o      (resp_out),
    .mem_resp_v_o    (resp_v),
    .mem_resp_yumi_i (yumi_in),
    .mem_cmd_o       (mcmd),
    .mem_cmd_v_o     (mcmd_v),
    .mem_cmd_ready_i (mcmd_rdy),
    .mem_resp_i      (mresp),
    .mem_resp_v_i    (mresp_v),
    .mem_resp_yumi_o (myumi),
`ifdef BP_ME_MEM_ARBITER_STATS_EN
    .stats_o         (stats),
`endif
    .outstanding_o   (outstanding)
  );

  typedef struct {
    logic [1:0] v;
    logic       mrdy;
    logic       rsp;
    logic [1:0] yumi;
    logic       exp_cmd_v;
    logic [1:0] exp_rdy;
    int         exp_gnt;
    logic [1:0] exp_rv;
    logic       exp_yumi;
    logic [2:0] exp_out;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_v    = '0;
    cmd_in   = '0;
    mcmd_rdy = 1'b0;
    mresp    = '0;
    mresp_v  = 1'b0;
    yumi_in  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives both requesters against an in-order memory; checks arbitration and routing per cycle.
  task automatic traffic(input int n_per, input logic [1:0] mask, input bit rnd);
    int sent [2];
    int recv [2];
    int need, cyc, m_ptr, m_cnt, eg, owner, last_due, ridx;
    bit any, push, pop;
    int oq[$];
    int due_q[$];
    logic [31:0] mq[$];
    sent = '{0, 0};
    recv = '{0, 0};
    need = n_per * (int'(mask[0]) + int'(mask[1]));
    m_ptr = 0; m_cnt = 0; cyc = 0; last_due = 0; owner = 0;
    while (recv[0] + recv[1] < need) begin
      if (cyc >= 5000) begin
        chk("traffic timeout", 64'(recv[0] + recv[1]), 64'(need));
        break;
      end
      @(negedge clk);
      chk("traffic outstanding", 64'(outstanding), 64'(m_cnt));
      for (int r = 0; r < 2; r++) begin
        if (!cmd_v[r] && mask[r] && sent[r] < n_per && (!rnd || $urandom_range(0, 3) != 0))
          cmd_v[r] = 1'b1;
        cmd_in[r*32 +: 32] = {4'(r), 28'(sent[r])};
      end
      mcmd_rdy = !rnd || ($urandom_range(0, 3) != 0);
      mresp_v  = (mq.size() > 0) && (due_q[0] <= cyc);
      mresp    = mresp_v ? mq[0] : '0;
      yumi_in  = '0;
      #1;
      yumi_in  = resp_v;
      #1;
      any = 1'b0;
      eg  = 0;
      for (int k = 0; k < 2; k++) begin
        ridx = (m_ptr + k) % 2;
        if (!any && cmd_v[ridx]) begin
          any = 1'b1;
          eg  = ridx;
        end
      end
      push = any && m_cnt < 4 && mcmd_rdy;
      chk("traffic cmd_v", 64'(mcmd_v), 64'(any && m_cnt < 4));
      chk("traffic cmd_ready", 64'(cmd_rdy), (m_cnt < 4 && mcmd_rdy) ? 64'(1 << eg) : 64'd0);
      if (any && m_cnt < 4) chk("traffic cmd data", 64'(mcmd), 64'({4'(eg), 28'(sent[eg])}));
      pop = mresp_v;
      if (mresp_v) begin
        owner = oq[0];
        chk("traffic resp route", 64'(resp_v), 64'(1 << owner));
        chk("traffic yumi", 64'(myumi), 64'd1);
        chk("traffic resp order", 64'(resp_out), 64'({4'(owner), 28'(recv[owner])}));
      end else begin
        chk("traffic idle resp_v", 64'(resp_v), 64'd0);
      end
      @(posedge clk);
      #1;
      if (push) begin
        mq.push_back({4'(eg), 28'(sent[eg])});
        sent[eg]++;
        cmd_v[eg] = 1'b0;
        oq.push_back(eg);
        ridx = cyc + 1 + (rnd ? int'($urandom_range(0, 14)) : 0);
        last_due = (ridx > last_due) ? ridx : last_due;
        due_q.push_back(last_due);
        m_ptr = (eg + 1) % 2;
        m_cnt++;
        glog.push_back(eg);
      end
      if (pop) begin
        recv[owner]++;
        void'(oq.pop_front());
        void'(mq.pop_front());
        void'(due_q.pop_front());
        m_cnt--;
      end
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    // v, mrdy, rsp, yumi | cmd_v, rdy, grant, resp_v, yumi_o, outstanding after edge
    tbl[0]  = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, -1, 2'b00, 1'b0, 3'd0};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00,  0, 2'b00, 1'b0, 3'd0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01,  0, 2'b00, 1'b0, 3'd1};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10,  1, 2'b01, 1'b1, 3'd1};
    tbl[4]  = '{2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10,  1, 2'b00, 1'b0, 3'd2};
    tbl[5]  = '{2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01,  0, 2'b00, 1'b0, 3'd3};
    tbl[6]  = '{2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 2'b01,  0, 2'b10, 1'b0, 3'd4};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00,  1, 2'b10, 1'b1, 3'd3};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10,  1, 2'b10, 1'b1, 3'd3};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01, -1, 2'b01, 1'b1, 3'd2};
    tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, -1, 2'b01, 1'b1, 3'd1};
    tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, -1, 2'b10, 1'b1, 3'd0};

    // Reset hold with busy inputs: every handshake output stays low.
    reset_n  = 1'b0;
    idle_inputs();
    cmd_v    = 2'b11;
    mcmd_rdy = 1'b1;
    mresp_v  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset cmd_v", 64'(mcmd_v), 64'd0);
    chk("reset cmd_ready", 64'(cmd_rdy), 64'd0);
    chk("reset resp_v", 64'(resp_v), 64'd0);
    chk("reset yumi", 64'(myumi), 64'd0);
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle cmd_v", 64'(mcmd_v), 64'd0);
    chk("idle resp_v", 64'(resp_v), 64'd0);
    chk("idle outstanding", 64'(outstanding), 64'd0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cmd_v    = tbl[i].v;
      mcmd_rdy = tbl[i].mrdy;
      mresp_v  = tbl[i].rsp;
      yumi_in  = tbl[i].yumi;
      cmd_in   = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      mresp    = 32'hC000_0000 + 32'(i);
      #1;
      chk($sformatf("row%0d cmd_v", i), 64'(mcmd_v), 64'(tbl[i].exp_cmd_v));
      chk($sformatf("row%0d cmd_ready", i), 64'(cmd_rdy), 64'(tbl[i].exp_rdy));
      if (tbl[i].exp_gnt >= 0)
        chk($sformatf("row%0d cmd data", i), 64'(mcmd),
            (tbl[i].exp_gnt == 1) ? 64'(32'hB000_0000 + 32'(i)) : 64'(32'hA000_0000 + 32'(i)));
      chk($sformatf("row%0d resp_v", i), 64'(resp_v), 64'(tbl[i].exp_rv));
      chk($sformatf("row%0d yumi", i), 64'(myumi), 64'(tbl[i].exp_yumi));
      chk($sformatf("row%0d resp data", i), 64'(resp_out), 64'(32'hC000_0000 + 32'(i)));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d outstanding", i), 64'(outstanding), 64'(tbl[i].exp_out));
    end
    idle_inputs();

    // Both requesters saturating with 1-cycle memory latency: grants alternate.
    do_reset();
    glog.delete();
    traffic(4, 2'b11, 1'b0);
    for (int k = 0; k < 4; k++) chk($sformatf("alt grant %0d", k), 64'(glog[k]), 64'(k % 2));

    // Fill the tag FIFO from req1; the 5th command waits for a pop, then goes next cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmd_v = 2'b10; mcmd_rdy = 1'b1; cmd_in = {32'h1000 + 32'(k), 32'h0};
    end
    @(negedge clk);
    chk("full outstanding", 64'(outstanding), 64'd4);
    chk("full cmd_ready a", 64'(cmd_rdy), 64'd0);
    chk("full cmd_v a", 64'(mcmd_v), 64'd0);
    @(negedge clk);
    chk("full cmd_ready b", 64'(cmd_rdy), 64'd0);
    mresp_v = 1'b1; mresp = 32'h5A5A; yumi_in = 2'b10;
    #1;
    chk("full pop cmd_ready", 64'(cmd_rdy), 64'd0);
    chk("full pop resp_v", 64'(resp_v), 64'b10);
    chk("full pop yumi", 64'(myumi), 64'd1);
    @(negedge clk);
    mresp_v = 1'b0; yumi_in = 2'b00;
    #1;
    chk("after pop cmd_ready", 64'(cmd_rdy), 64'b10);
    chk("after pop cmd_v", 64'(mcmd_v), 64'd1);
    @(posedge clk);
    #1;
    chk("after pop outstanding", 64'(outstanding), 64'd4);
    idle_inputs();

    // Reset with a command in flight drops its tag; the late response is not routed.
    do_reset();
    @(negedge clk);
    cmd_v = 2'b01; mcmd_rdy = 1'b1; cmd_in = {32'h0, 32'h77};
    @(posedge clk);
    #1;
    chk("inflight outstanding", 64'(outstanding), 64'd1);
    do_reset();
    @(negedge clk);
    chk("post reset outstanding", 64'(outstanding), 64'd0);
    mresp_v = 1'b1; mresp = 32'h77;
    #1;
    chk("late resp_v", 64'(resp_v), 64'd0);
    chk("late yumi", 64'(myumi), 64'd0);
    idle_inputs();

    // Mixed random traffic with up to 15 cycles of memory latency.
    do_reset();
    traffic(100, 2'b11, 1'b1);

`ifdef BP_ME_MEM_ARBITER_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_v = 2'b01; mcmd_rdy = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd_v = 2'b10; mcmd_rdy = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
    chk("stats req0", stats[63:0], {32'd0, 32'd3});
    chk("stats req1", stats[127:64], {32'd2, 32'd0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
